ghash_ctrl: RTL and testbench

GHASH_CTRL -- requirements
Module: ghash_ctrl

---
 rtl/gcm_pkg.sv | 22 ++
 rtl/ghash_lenblk.sv | 15 +
 rtl/ghash_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ghash_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// rtl/gcm_pkg.sv - shared GHASH controller types, block-type codes and width constant
package gcm_pkg;

  localparam int GCM_W = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    MUL    = 3'd2,
    LEN    = 3'd3,
    DONE   = 3'd4
  } ghash_state_t;

  localparam logic BLK_AAD = 1'b0;
  localparam logic BLK_CT  = 1'b1;

  // A zero byte count encodes a full 16-byte block
  function automatic logic [4:0] eff_nbytes(input logic [4:0] nbytes);
    return (nbytes == 5'd0) ? 5'd16 : nbytes;
  endfunction

endpackage

// File: rtl/ghash_lenblk.sv
// rtl/ghash_lenblk.sv - builds the GHASH length block {aad_bits, ct_bits} from byte counters
module ghash_lenblk
  import gcm_pkg::*;
(
  input  logic [31:0]      aad_bytes,
  input  logic [31:0]      ct_bytes,
  output logic [GCM_W-1:0] len_block
);

  // Counters are zero-extended to 64 bits, then scaled to bits (x8)
  always_comb begin
    len_block = {29'd0, aad_bytes, 3'd0, 29'd0, ct_bytes, 3'd0};
  end

endmodule

// File: rtl/ghash_ctrl.sv
// rtl/ghash_ctrl.sv - GHASH sequencer driving an external GF(2^128) multiplier (option: GHASH_CTRL_PARTIAL_MASK_EN)
module ghash_ctrl
  import gcm_pkg::*;
#(
  parameter int MUL_TIMEOUT = 64
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic [127:0] iHashkey,
  input  logic         iHashkey_valid,
  input  logic         iStart,
  input  logic [127:0] iBlock,
  input  logic         iBlock_valid,
  input  logic         iBlock_type,
  input  logic         iBlock_last,
  input  logic [4:0]   iBlock_nbytes,
  output logic         oBlock_ready,
  output logic [127:0] oMul_a,
  output logic [127:0] oMul_h,
  output logic         oMul_valid,
  input  logic [127:0] iMul_result,
  input  logic         iMul_valid,
  output logic [127:0] oTag,
  output logic         oTag_valid,
  output logic         oBusy,
  output logic         oErr
);

  localparam int TMO_W = $clog2(MUL_TIMEOUT + 1);

  ghash_state_t     state;
  logic [GCM_W-1:0] y;
  logic [GCM_W-1:0] h;
  logic             h_valid;
  logic             last_flag;
  logic             final_flag;
  logic [31:0]      aad_bytes;
  logic [31:0]      ct_bytes;
  logic [TMO_W-1:0] tmo_cnt;
  logic [4:0]       nb_eff;
  logic [GCM_W-1:0] blk_in;
  logic [GCM_W-1:0] len_block;

  // Effective byte count and the block value as it will be folded into Y
  always_comb begin
    nb_eff = eff_nbytes(iBlock_nbytes);
`ifdef GHASH_CTRL_PARTIAL_MASK_EN
    blk_in = iBlock & ({GCM_W{1'b1}} << (8 * (16 - int'(nb_eff))));
`else
    blk_in = iBlock;
`endif
  end

  ghash_lenblk u_lenblk (
    .aad_bytes (aad_bytes),
    .ct_bytes  (ct_bytes),
    .len_block (len_block)
  );

  // Message sequencer: absorb blocks, wait on the multiplier, finish with the length block
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= IDLE;
      y            <= '0;
      h            <= '0;
      h_valid      <= 1'b0;
      last_flag    <= 1'b0;
      final_flag   <= 1'b0;
      aad_bytes    <= '0;
      ct_bytes     <= '0;
      tmo_cnt      <= '0;
      oBlock_ready <= 1'b0;
      oMul_a       <= '0;
      oMul_h       <= '0;
      oMul_valid   <= 1'b0;
      oTag         <= '0;
      oTag_valid   <= 1'b0;
      oBusy        <= 1'b0;
      oErr         <= 1'b0;
    end else begin
      oMul_valid <= 1'b0;
      oTag_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (iHashkey_valid) begin
            h       <= iHashkey;
            h_valid <= 1'b1;
          end
          if (iStart && h_valid) begin
            y            <= '0;
            aad_bytes    <= '0;
            ct_bytes     <= '0;
            final_flag   <= 1'b0;
            oErr         <= 1'b0;
            oBlock_ready <= 1'b1;
            oBusy        <= 1'b1;
            state        <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (iBlock_valid) begin
            if (iBlock_type == BLK_CT) begin
              ct_bytes <= ct_bytes + 32'(nb_eff);
            end else begin
              aad_bytes <= aad_bytes + 32'(nb_eff);
              // Any CT transfer leaves ct_bytes non-zero, so this flags AAD after CT
              if (ct_bytes != 32'd0) oErr <= 1'b1;
            end
            oMul_a       <= y ^ blk_in;
            oMul_h       <= h;
            oMul_valid   <= 1'b1;
            last_flag    <= iBlock_last;
            tmo_cnt      <= '0;
            oBlock_ready <= 1'b0;
            state        <= MUL;
          end
        end
        MUL: begin
          if (iMul_valid) begin
            if (final_flag) begin
              oTag       <= iMul_result;
              oTag_valid <= 1'b1;
              state      <= DONE;
            end else begin
              y <= iMul_result;
              if (last_flag) begin
                state <= LEN;
              end else begin
                oBlock_ready <= 1'b1;
                state        <= ACCEPT;
              end
            end
          end else if (tmo_cnt == TMO_W'(MUL_TIMEOUT - 1)) begin
            oErr  <= 1'b1;
            oBusy <= 1'b0;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        LEN: begin
          oMul_a     <= y ^ len_block;
          oMul_h     <= h;
          oMul_valid <= 1'b1;
          final_flag <= 1'b1;
          tmo_cnt    <= '0;
          state      <= MUL;
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oBusy        <= 1'b0;
          oBlock_ready <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// tb/tb_ghash_ctrl.sv - randomized self-checking bench for ghash_ctrl with a behavioural multiplier
module tb_ghash_ctrl;

  localparam int MUL_TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] hkey = '0;
  logic         hvalid = 1'b0;
  logic         start = 1'b0;
  logic [127:0] blk = '0;
  logic         bvalid = 1'b0;
  logic         btype = 1'b0;
  logic         blast = 1'b0;
  logic [4:0]   bnb = '0;
  logic         blk_ready;
  logic [127:0] mul_a;
  logic [127:0] mul_h;
  logic         mul_valid_out;
  logic [127:0] mul_result_in;
  logic         mul_valid_in;
  logic [127:0] tag;
  logic         tag_valid;
  logic         busy;
  logic         err;

  logic         resp_valid = 1'b0;
  logic [127:0] resp_result = '0;
  logic         late_valid = 1'b0;
  logic [127:0] late_result = '0;
  bit           mul_mute = 1'b0;
  logic [127:0] resp_tmp;
  int           resp_lat;

  logic [127:0] cap_q[$];
  logic [127:0] m_blk[$];
  logic         m_type[$];
  logic [4:0]   m_nb[$];

  int tests_run = 0;
  int tests_failed = 0;

  assign mul_valid_in  = resp_valid | late_valid;
  assign mul_result_in = late_valid ? late_result : resp_result;

  ghash_ctrl #(.MUL_TIMEOUT(MUL_TIMEOUT)) dut (
    .iClk           (clk),
    .iRst           (rst),
    .iHashkey       (hkey),
    .iHashkey_valid (hvalid),
    .iStart         (start),
    .iBlock         (blk),
    .iBlock_valid   (bvalid),
    .iBlock_type    (btype),
    .iBlock_last    (blast),
    .iBlock_nbytes  (bnb),
    .oBlock_ready   (blk_ready),
    .oMul_a         (mul_a),
    .oMul_h         (mul_h),
    .oMul_valid     (mul_valid_out),
    .iMul_result    (mul_result_in),
    .iMul_valid     (mul_valid_in),
    .oTag           (tag),
    .oTag_valid     (tag_valid),
    .oBusy          (busy),
    .oErr           (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // GF(2^128) product in GCM bit order (bit 127 is x^0)
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] yv);
    logic [127:0] z = '0;
    logic [127:0] v = yv;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z ^= v;
      if (v[0]) v = (v >> 1) ^ {8'hE1, 120'd0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  // GHASH over the queued message, including the length block
  function automatic logic [127:0] ghash_model(input logic [127:0] hk);
    logic [127:0] acc = '0;
    logic [63:0]  abits = '0;
    logic [63:0]  cbits = '0;
    int n;
    foreach (m_blk[i]) begin
      acc = gf_mul(acc ^ m_blk[i], hk);
      n = (m_nb[i] == 5'd0) ? 16 : int'(m_nb[i]);
      if (m_type[i]) cbits += 64'(n * 8);
      else           abits += 64'(n * 8);
    end
    return gf_mul(acc ^ {abits, cbits}, hk);
  endfunction

  function automatic logic [127:0] pad(input logic [127:0] d, input int n);
    for (int b = n; b < 16; b++) d[127-8*b -: 8] = 8'h00;
    return d;
  endfunction

  // Behavioural multiplier: answers each request after a random latency
  initial forever begin
    @(negedge clk);
    if (mul_valid_out) begin
      cap_q.push_back(mul_a);
      if (!mul_mute) begin
        resp_tmp = gf_mul(mul_a, mul_h);
        resp_lat = $urandom_range(0, 4);
        repeat (resp_lat) @(negedge clk);
        resp_result = resp_tmp;
        resp_valid  = 1'b1;
        @(negedge clk);
        resp_valid  = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_h(input logic [127:0] hv);
    hkey = hv; hvalid = 1'b1; tick(); hvalid = 1'b0;
  endtask

  task automatic start_msg();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic t, input logic l, input logic [4:0] n);
    blk = d; btype = t; blast = l; bnb = n; bvalid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (blk_ready) break;
      tick();
    end
    check("ready_wait", {127'd0, blk_ready}, 128'd1);
    tick();
    bvalid = 1'b0;
  endtask

  task automatic wait_done(output logic [127:0] t, output int pulses);
    pulses = 0;
    t = '0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (tag_valid) begin
        pulses++;
        t = tag;
      end
      if (!busy) break;
    end
    check("done_wait", {127'd0, busy}, 128'd0);
  endtask

  task automatic run_msg(output logic [127:0] t, output int pulses);
    cap_q.delete();
    start_msg();
    foreach (m_blk[i]) send_block(m_blk[i], m_type[i], (i == m_blk.size() - 1), m_nb[i]);
    wait_done(t, pulses);
  endtask

  task automatic set_msg1(input logic [127:0] d, input logic t, input logic [4:0] n);
    m_blk.delete(); m_type.delete(); m_nb.delete();
    m_blk.push_back(d); m_type.push_back(t); m_nb.push_back(n);
  endtask

  logic [127:0] h1 = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
  logic [127:0] h2 = 128'h73A23D80121DE2D5A850253FCF43120E;
  logic [127:0] got_tag;
  logic [127:0] exp_tag;
  logic [127:0] rb;
  logic [127:0] rh;
  int           npulse;
  int           nb;

  // Directed scenarios followed by randomized messages
  initial begin
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);
    check("rst_tag", tag, 128'd0);
    check("rst_mul_a", mul_a, 128'd0);
    check("rst_mul_h", mul_h, 128'd0);
    check("rst_flags", {125'd0, blk_ready, tag_valid, mul_valid_out}, 128'd0);

    start_msg();
    check("start_no_h", {127'd0, busy}, 128'd0);

    // Single full CT block with the standard GCM key
    load_h(h1);
    set_msg1(128'h0388DACE60B6A392F328C2B971B2FE78, 1'b1, 5'd16);
    run_msg(got_tag, npulse);
    check("t1_ncap", 128'(cap_q.size()), 128'd2);
    check("t1_a0", cap_q[0], 128'h0388DACE60B6A392F328C2B971B2FE78);
    check("t1_y1", cap_q[1] ^ {64'd0, 64'd128}, 128'h5E2EC746917062882C85B0685353DEB7);
    check("t1_tag", got_tag, 128'hF38CBB1AD69223DCC3457AE5B6B0F885);
    check("t1_pulses", 128'(npulse), 128'd1);
    repeat (5) tick();
    check("t1_tag_hold", tag, 128'hF38CBB1AD69223DCC3457AE5B6B0F885);

    // All-zero block: Y stays zero, only the length contributes
    set_msg1(128'd0, 1'b1, 5'd0);
    run_msg(got_tag, npulse);
    check("t2_len", cap_q[1], {64'd0, 64'd128});
    check("t2_tag", got_tag, ghash_model(h1));
    check("t2_err", {127'd0, err}, 128'd0);

    // AAD full block then 12-byte CT block
    load_h(h2);
    m_blk.delete(); m_type.delete(); m_nb.delete();
    m_blk.push_back(128'hD609B1F056637A0D46DF998D88E52E00); m_type.push_back(1'b0); m_nb.push_back(5'd16);
    m_blk.push_back(128'hB2C2846512153524C0895E8100000000); m_type.push_back(1'b1); m_nb.push_back(5'd12);
    run_msg(got_tag, npulse);
    check("t3_ncap", 128'(cap_q.size()), 128'd3);
    check("t3_y1", cap_q[1] ^ 128'hB2C2846512153524C0895E8100000000, 128'h9CABBD91899C1413AA7AD629C1DF12CD);
    check("t3_len", cap_q[2] ^ 128'hB99ABF6BDBD18B8E148F8030F0686F28, {64'd128, 64'd96});
    check("t3_tag", got_tag, ghash_model(h2));
    check("t3_err", {127'd0, err}, 128'd0);

    // AAD after CT raises a sticky error but is still absorbed
    m_blk.delete(); m_type.delete(); m_nb.delete();
    m_blk.push_back(128'h0123456789ABCDEF0011223344556677); m_type.push_back(1'b1); m_nb.push_back(5'd16);
    m_blk.push_back(128'hFEDCBA98765432100000000000000000); m_type.push_back(1'b0); m_nb.push_back(5'd8);
    cap_q.delete();
    start_msg();
    send_block(m_blk[0], m_type[0], 1'b0, m_nb[0]);
    check("t4_err_pre", {127'd0, err}, 128'd0);
    send_block(m_blk[1], m_type[1], 1'b1, m_nb[1]);
    check("t4_err_set", {127'd0, err}, 128'd1);
    wait_done(got_tag, npulse);
    check("t4_tag", got_tag, ghash_model(h2));
    repeat (3) tick();
    check("t4_err_hold", {127'd0, err}, 128'd1);
    start_msg();
    check("t4_err_clr", {127'd0, err}, 128'd0);
    send_block(128'd0, 1'b0, 1'b1, 5'd16);
    wait_done(got_tag, npulse);

    // Multiplier never answers: timeout error and return to IDLE
    mul_mute = 1'b1;
    start_msg();
    send_block(128'h1, 1'b0, 1'b1, 5'd16);
    repeat (MUL_TIMEOUT + 8) tick();
    check("tmo_err", {127'd0, err}, 128'd1);
    check("tmo_busy", {127'd0, busy}, 128'd0);

    // Reset while waiting in MUL, then a stray multiplier response
    start_msg();
    send_block(128'h2, 1'b1, 1'b1, 5'd16);
    repeat (3) tick();
    check("rm_busy_pre", {127'd0, busy}, 128'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rm_busy", {127'd0, busy}, 128'd0);
    check("rm_err", {127'd0, err}, 128'd0);
    check("rm_tag", tag, 128'd0);
    check("rm_mul", mul_a | mul_h, 128'd0);
    check("rm_flags", {125'd0, blk_ready, tag_valid, mul_valid_out}, 128'd0);
    late_result = {$urandom, $urandom, $urandom, $urandom};
    late_valid = 1'b1; tick(); late_valid = 1'b0;
    repeat (3) tick();
    check("rm_late_busy", {127'd0, busy}, 128'd0);
    check("rm_late_tag", tag, 128'd0);
    mul_mute = 1'b0;

    // Random well-ordered messages against the GHASH model
    for (int r = 0; r < 8; r++) begin
      rh = {$urandom, $urandom, $urandom, $urandom};
      load_h(rh);
      m_blk.delete(); m_type.delete(); m_nb.delete();
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        nb = $urandom_range(0, 16);
        rb = {$urandom, $urandom, $urandom, $urandom};
        m_blk.push_back(pad(rb, (nb == 0) ? 16 : nb));
        m_type.push_back(1'b0);
        m_nb.push_back(5'(nb));
      end
      for (int j = 0; j < m_blk.size(); j++) m_type[j] = (j >= int'($urandom_range(0, 3)));
      for (int j = 1; j < m_blk.size(); j++) if (m_type[j-1]) m_type[j] = 1'b1;
      run_msg(got_tag, npulse);
      exp_tag = ghash_model(rh);
      check($sformatf("rand%0d_tag", r), got_tag, exp_tag);
      check($sformatf("rand%0d_err", r), {127'd0, err}, 128'd0);
      check($sformatf("rand%0d_pulse", r), 128'(npulse), 128'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
